// File: rtl/draw_pkg.sv
// Shared drawing definitions for the vga_adapter write path: screen geometry,
// pixel field widths, common colours and the block painter state encoding.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] BLUE  = 3'b001;
    localparam logic [COLOUR_W-1:0] RED   = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Raster position counter for a W x H rectangle: cx runs fastest, cy steps on
// each cx wrap, and last flags the bottom-right pixel.
module rect_scan_counter
    import draw_pkg::*;
#(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last
);

    logic col_end;
    logic row_end;

    assign col_end = (cx == X_W'(W - 1));
    assign row_end = (cy == Y_W'(H - 1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (advance) begin
            if (col_end) begin
                cx <= '0;
                cy <= cy + Y_W'(1);
            end else begin
                cx <= cx + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/block_painter.sv
// Scans one filled game block (slot 0..3) and drives vga_adapter one pixel per
// clock, with a start/busy/done handshake toward the game logic.
module block_painter
    import draw_pkg::*;
#(
    parameter int BLOCK_W  = 16,
    parameter int BLOCK_H  = 16,
    parameter int X_BASE   = 8,
    parameter int X_PITCH  = 40,
    parameter int Y_ORIGIN = 33
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          slot,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    if (BLOCK_W < 1 || BLOCK_H < 1 ||
        X_BASE + 3 * X_PITCH + BLOCK_W > SCREEN_W ||
        Y_ORIGIN + BLOCK_H > SCREEN_H) begin : g_bad_geometry
        $error("block_painter: block geometry does not fit on the 160x120 screen");
    end

    state_t         state;
    state_t         state_n;
    logic           accept;
    logic           step;
    logic [X_W-1:0] ox;
    logic [X_W-1:0] start_x;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic           last;
    logic           col_end;

    assign start_x = X_W'(X_BASE + int'(slot) * X_PITCH);
    assign col_end = (cx == X_W'(BLOCK_W - 1));

    rect_scan_counter #(
        .W (BLOCK_W),
        .H (BLOCK_H)
    ) u_scan (
        .clk     (CLOCK_50),
        .rst     (reset),
        .clear   (accept),
        .advance (step),
        .cx      (cx),
        .cy      (cy),
        .last    (last)
    );

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SCAN;
                    accept  = 1'b1;
                end
            end
            SCAN: begin
                if (last) begin
                    state_n = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pixel 0 is registered on the accepting edge so the first plot lands in
    // the very next cycle; the counter then tracks the pixel currently shown.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            plot   <= 1'b0;
            ox     <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
            plot  <= (state_n == SCAN);
            if (accept) begin
                ox     <= start_x;
                x      <= start_x;
                y      <= Y_W'(Y_ORIGIN);
                colour <= colour_in;
            end else if (step) begin
                if (col_end) begin
                    x <= ox;
                    y <= Y_W'(Y_ORIGIN) + cy + Y_W'(1);
                end else begin
                    x <= x + X_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_block_painter.sv
// Randomised and directed bench for block_painter: a 16x16 and a 1x3 instance
// share one stimulus and are checked every cycle against a per-block cycle model.
module tb_block_painter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] slot;
    logic [2:0] colour_in;

    logic       busy_d [2];
    logic       done_d [2];
    logic       plot_d [2];
    logic [7:0] x_d    [2];
    logic [6:0] y_d    [2];
    logic [2:0] col_d  [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    block_painter u_big (
        .CLOCK_50  (clk),
        .reset     (rst),
        .start     (start),
        .slot      (slot),
        .colour_in (colour_in),
        .busy      (busy_d[0]),
        .done      (done_d[0]),
        .x         (x_d[0]),
        .y         (y_d[0]),
        .colour    (col_d[0]),
        .plot      (plot_d[0])
    );

    block_painter #(
        .BLOCK_W (1),
        .BLOCK_H (3)
    ) u_small (
        .CLOCK_50  (clk),
        .reset     (rst),
        .start     (start),
        .slot      (slot),
        .colour_in (colour_in),
        .busy      (busy_d[1]),
        .done      (done_d[1]),
        .x         (x_d[1]),
        .y         (y_d[1]),
        .colour    (col_d[1]),
        .plot      (plot_d[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: ph counts cycles since the accepting edge (0 = idle); pixel k of a
    // block is shown in cycle k+1, done in cycle W*H+1.
    int mw [2] = '{16, 1};
    int mh [2] = '{16, 3};
    int ph [2] = '{0, 0};
    int mox[2] = '{0, 0};
    int mcl[2] = '{0, 0};
    int ex [2] = '{0, 0};
    int ey [2] = '{0, 0};
    int ec [2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        for (int m = 0; m < 2; m++) begin
            int n;
            n = mw[m] * mh[m];
            if (rst) begin
                ph[m] = 0; ex[m] = 0; ey[m] = 0; ec[m] = 0;
            end else begin
                if (ph[m] == 0) begin
                    if (start) begin
                        ph[m]  = 1;
                        mox[m] = 8 + int'(slot) * 40;
                        mcl[m] = int'(colour_in);
                    end
                end else if (ph[m] == n + 1) begin
                    ph[m] = 0;
                end else begin
                    ph[m]++;
                end
                if (ph[m] >= 1 && ph[m] <= n) begin
                    ex[m] = mox[m] + (ph[m] - 1) % mw[m];
                    ey[m] = 33 + (ph[m] - 1) / mw[m];
                    ec[m] = mcl[m];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int n;
            n = mw[m] * mh[m];
            chk(m == 1 ? "small.busy"   : "big.busy",   int'(busy_d[m]), int'(ph[m] >= 1));
            chk(m == 1 ? "small.done"   : "big.done",   int'(done_d[m]), int'(ph[m] == n + 1));
            chk(m == 1 ? "small.plot"   : "big.plot",   int'(plot_d[m]), int'(ph[m] >= 1 && ph[m] <= n));
            chk(m == 1 ? "small.x"      : "big.x",      int'(x_d[m]),    ex[m]);
            chk(m == 1 ? "small.y"      : "big.y",      int'(y_d[m]),    ey[m]);
            chk(m == 1 ? "small.colour" : "big.colour", int'(col_d[m]),  ec[m]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_d[0] && !busy_d[1]) begin
                tick();
                return;
            end
            tick();
        end
        miscompares++;
        $display("FAIL wait_idle: busy still high after %0d cycles", budget);
    endtask

    // Pulses start for one cycle and records what the 16x16 and 1x3 blocks do,
    // with cycle 0 being the cycle in which start is sampled.
    task automatic run_block(input logic [1:0] s, input logic [2:0] c,
                             output int np, output int fx, output int fy, output int fc,
                             output int lx, output int ly, output int dcyc, output int bcyc,
                             output int ndone, output int snp, output int sdc);
        np = 0; fx = -1; fy = -1; fc = -1; lx = -1; ly = -1;
        dcyc = -1; bcyc = -1; ndone = 0; snp = 0; sdc = -1;
        start = 1'b1; slot = s; colour_in = c;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 262; cyc++) begin
            @(negedge clk);
            if (plot_d[0]) begin
                np++;
                if (fc < 0) begin fx = int'(x_d[0]); fy = int'(y_d[0]); fc = cyc; end
                lx = int'(x_d[0]); ly = int'(y_d[0]);
            end
            if (done_d[0]) begin ndone++; if (dcyc < 0) dcyc = cyc; end
            if (!busy_d[0] && bcyc < 0) bcyc = cyc;
            if (plot_d[1]) snp++;
            if (done_d[1] && sdc < 0) sdc = cyc;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, fx, fy, fc, lx, ly, dcyc, bcyc, ndone, snp, sdc;
        int blk, gap, minx, maxx, min2, max2, badcol, seen2;

        rst = 1'b1; start = 1'b0; slot = '0; colour_in = '0;
        tick(); tick(); tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        chk("idle.plot", int'(plot_d[0]), 0);
        chk("idle.busy", int'(busy_d[0]), 0);
        chk("idle.done", int'(done_d[0]), 0);
        chk("idle.x",    int'(x_d[0]),    0);
        chk("idle.y",    int'(y_d[0]),    0);
        chk("idle.col",  int'(col_d[0]),  0);
        tick();

        // Single block, slot 2, red
        run_block(2'd2, 3'b100, np, fx, fy, fc, lx, ly, dcyc, bcyc, ndone, snp, sdc);
        chk("model.ox_slot2", mox[0], 88);
        chk("s2.first_x", fx, 88);
        chk("s2.first_y", fy, 33);
        chk("s2.first_cycle", fc, 1);
        chk("s2.last_x", lx, 103);
        chk("s2.last_y", ly, 48);
        chk("s2.plots", np, 256);
        chk("s2.done_cycle", dcyc, 257);
        chk("s2.busy_low_cycle", bcyc, 258);
        chk("s2.done_count", ndone, 1);
        chk("w1h3.plots", snp, 3);
        chk("w1h3.done_cycle", sdc, 4);

        // Back-to-back: start held, slot 0 then slot 3
        start = 1'b1; slot = 2'd0; colour_in = 3'b001;
        tick();
        slot = 2'd3; colour_in = 3'b010;
        blk = 0; gap = 0; seen2 = 0;
        minx = 255; maxx = -1; min2 = 255; max2 = -1;
        for (int cyc = 1; cyc <= 700 && blk < 2; cyc++) begin
            @(negedge clk);
            if (plot_d[0]) begin
                if (blk == 0) begin
                    if (int'(x_d[0]) < minx) minx = int'(x_d[0]);
                    if (int'(x_d[0]) > maxx) maxx = int'(x_d[0]);
                end else begin
                    seen2 = 1;
                    start = 1'b0;
                    if (int'(x_d[0]) < min2) min2 = int'(x_d[0]);
                    if (int'(x_d[0]) > max2) max2 = int'(x_d[0]);
                end
            end else if (done_d[0]) begin
                blk++;
            end else if (blk == 1 && !seen2) begin
                gap++;
            end
            tick();
        end
        start = 1'b0;
        chk("b2b.blocks_done", blk, 2);
        chk("b2b.gap_cycles", gap, 1);
        chk("b2b.blk0_minx", minx, 8);
        chk("b2b.blk0_maxx", maxx, 23);
        chk("b2b.blk1_minx", min2, 128);
        chk("b2b.blk1_maxx", max2, 143);
        wait_idle(400);

        // Inputs changed during a scan of slot 1 must be ignored
        start = 1'b1; slot = 2'd1; colour_in = 3'b010;
        tick();
        np = 0; ndone = 0; minx = 255; maxx = -1; badcol = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (plot_d[0]) begin
                np++;
                if (int'(x_d[0]) < minx) minx = int'(x_d[0]);
                if (int'(x_d[0]) > maxx) maxx = int'(x_d[0]);
                if (col_d[0] != 3'b010) badcol++;
            end
            if (done_d[0]) ndone++;
            tick();
            if (cyc < 250) begin
                start     = 1'($urandom_range(0, 1));
                slot      = 2'($urandom_range(0, 3));
                colour_in = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
        end
        chk("ign.plots", np, 256);
        chk("ign.dones", ndone, 1);
        chk("ign.minx", minx, 48);
        chk("ign.maxx", maxx, 63);
        chk("ign.bad_colour", badcol, 0);
        wait_idle(400);

        // Reset in the middle of a slot 3 scan
        start = 1'b1; slot = 2'd3; colour_in = 3'b111;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 99; cyc++) tick();
        @(negedge clk);
        chk("rst.pix100_plot", int'(plot_d[0]), 1);
        chk("rst.pix100_x", int'(x_d[0]), 131);
        chk("rst.pix100_y", int'(y_d[0]), 39);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst.plot_drop", int'(plot_d[0]), 0);
        chk("rst.busy_drop", int'(busy_d[0]), 0);
        chk("rst.done_none", int'(done_d[0]), 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        run_block(2'd0, 3'b101, np, fx, fy, fc, lx, ly, dcyc, bcyc, ndone, snp, sdc);
        chk("rst.fresh_first_x", fx, 8);
        chk("rst.fresh_first_y", fy, 33);
        chk("rst.fresh_plots", np, 256);
        chk("rst.fresh_last_x", lx, 23);
        chk("rst.fresh_last_y", ly, 48);
        chk("rst.fresh_dones", ndone, 1);

        // Random traffic, model-checked every cycle
        for (int it = 0; it < 10; it++) begin
            int idle_n;
            int hold_n;
            idle_n = int'($urandom_range(0, 5));
            hold_n = int'($urandom_range(1, 3));
            for (int i = 0; i < idle_n; i++) tick();
            start = 1'b1;
            slot = 2'($urandom_range(0, 3));
            colour_in = 3'($urandom_range(0, 7));
            for (int i = 0; i < hold_n; i++) tick();
            for (int i = 0; i < 200; i++) begin
                start = ($urandom_range(0, 3) == 0);
                slot = 2'($urandom_range(0, 3));
                colour_in = 3'($urandom_range(0, 7));
                tick();
            end
            start = 1'b0;
            wait_idle(400);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
